// File: rtl/conv_enc_k7.sv
// rtl/conv_enc_k7.sv - rate-1/2 K=7 convolutional encoder with zero-tail termination
//
// Purpose:
//    Encodes a framed serial bit stream into one 2-bit code pair per bit using
//    generators G0 (octal 171) and G1 (octal 133). After the last bit of each
//    frame, K-1 zero tail bits are encoded so the decoder trellis ends in state 0.
//
// Ports:
//    clk        in   clock, rising edge
//    rst_n      in   asynchronous active-low reset
//    in_bit     in   information bit
//    in_valid   in   in_bit/in_last valid
//    in_last    in   final information bit of a frame
//    in_ready   out  encoder accepts input this cycle
//    out_pair   out  {G0 parity, G1 parity}
//    out_valid  out  out_pair/out_last valid
//    out_last   out  final tail pair of a frame
//    out_ready  in   downstream accepts output this cycle
//    busy       out  tail in progress or output pending
module conv_enc_k7 #(
   parameter int         K  = 7,
   parameter logic [6:0] G0 = 7'b1111001,
   parameter logic [6:0] G1 = 7'b1011011
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_bit,
   input  logic       in_valid,
   input  logic       in_last,
   output logic       in_ready,
   output logic [1:0] out_pair,
   output logic       out_valid,
   output logic       out_last,
   input  logic       out_ready,
   output logic       busy
);

   localparam int TW = $clog2(K);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_TAIL = 1'b1
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [TW-1:0]   r_tail_cnt;
   logic [TW-1:0]   w_tail_cnt_nxt;
   logic [K-2:0]    r_sr;
   logic [1:0]      r_out_pair;
   logic            r_out_valid;
   logic            r_out_last;

   logic            w_out_free;
   logic            w_in_fire;
   logic            w_tail_step;
   logic            w_load;
   logic            w_last_nxt;
   logic            w_b;
   logic [K-1:0]    w_w;
   logic [1:0]      w_pair;

   // The output slot is free when empty or being drained this same cycle,
   // which is what allows one pair per clock under continuous ready.
   assign w_out_free  = ~r_out_valid | out_ready;
   assign in_ready    = (r_state == S_IDLE) & w_out_free;
   assign w_in_fire   = in_valid & in_ready;
   assign w_tail_step = (r_state == S_TAIL) & w_out_free;
   assign w_load      = w_in_fire | w_tail_step;

   // Tail steps feed zeros into the shift register.
   assign w_b    = (r_state == S_IDLE) ? in_bit : 1'b0;
   assign w_w    = {w_b, r_sr};
   assign w_pair = {^(w_w & G0), ^(w_w & G1)};

   always_comb begin
      w_state_nxt    = r_state;
      w_tail_cnt_nxt = r_tail_cnt;
      w_last_nxt     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_in_fire && in_last) begin
               w_state_nxt    = S_TAIL;
               w_tail_cnt_nxt = TW'(K - 1);
            end
         end
         S_TAIL: begin
            if (w_out_free) begin
               w_tail_cnt_nxt = r_tail_cnt - 1'b1;
               if (r_tail_cnt == TW'(1)) begin
                  w_last_nxt  = 1'b1;
                  w_state_nxt = S_IDLE;
               end
            end
         end
         default: begin
            w_state_nxt    = S_IDLE;
            w_tail_cnt_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_tail_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_tail_cnt <= w_tail_cnt_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sr <= '0;
      end else if (w_load) begin
         r_sr <= w_w[K-1:1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_pair  <= 2'b00;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
      end else if (w_load) begin
         r_out_pair  <= w_pair;
         r_out_valid <= 1'b1;
         r_out_last  <= w_last_nxt;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign out_pair  = r_out_pair;
   assign out_valid = r_out_valid;
   assign out_last  = r_out_last;
   assign busy      = (r_state == S_TAIL) | r_out_valid;

endmodule

// File: tb/tb_conv_enc_k7.sv
// tb/tb_conv_enc_k7.sv - randomized self-checking bench for conv_enc_k7
module tb_conv_enc_k7;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_bit;
   logic       in_valid;
   logic       in_last;
   logic       in_ready;
   logic [1:0] out_pair;
   logic       out_valid;
   logic       out_last;
   logic       out_ready;
   logic       busy;

   int checks = 0;
   int errors = 0;

   bit         tx_b[$];
   bit         tx_l[$];
   logic [1:0] ex_p[$];
   bit         ex_l[$];

   always #5 clk = ~clk;

   conv_enc_k7 dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_bit    (in_bit),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .out_pair  (out_pair),
      .out_valid (out_valid),
      .out_last  (out_last),
      .out_ready (out_ready),
      .busy      (busy)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference: each code pair is the mod-2 sum of the generator taps applied
   // to the current and six previous bits of a zero-started, zero-padded frame.
   task automatic add_frame(input int n, input logic [255:0] v);
      logic [6:0] g0;
      logic [6:0] g1;
      int s0;
      int s1;
      g0 = 7'b1111001;
      g1 = 7'b1011011;
      for (int i = 0; i < n; i++) begin
         tx_b.push_back(v[i]);
         tx_l.push_back(i == n - 1);
      end
      for (int t = 0; t < n + 6; t++) begin
         s0 = 0;
         s1 = 0;
         for (int j = 0; j < 7; j++) begin
            if (t - j >= 0 && t - j < n) begin
               if (v[t-j]) begin
                  s0 += int'(g0[6-j]);
                  s1 += int'(g1[6-j]);
               end
            end
         end
         ex_p.push_back({1'(s0 % 2), 1'(s1 % 2)});
         ex_l.push_back(t == n + 5);
      end
   endtask

   task automatic run(input int rdy_pct, input int vld_pct, output int rlow, output int gaps);
      int         ti;
      int         cyc;
      bit         hold;
      logic [1:0] hp;
      logic       hl;
      bit         started;
      bit         seen_out;
      logic [1:0] ep;
      bit         el;
      ti = 0; cyc = 0; hold = 0; hp = 2'b00; hl = 1'b0;
      started = 0; seen_out = 0;
      rlow = 0; gaps = 0;
      while (ex_p.size() > 0 && cyc < 60000) begin
         @(posedge clk);
         #1;
         out_ready = ($urandom_range(99) < rdy_pct);
         if (ti < tx_b.size() && $urandom_range(99) < vld_pct) begin
            in_valid = 1'b1;
            in_bit   = tx_b[ti];
            in_last  = tx_l[ti];
         end else begin
            in_valid = 1'b0;
            in_bit   = 1'($urandom_range(1));
            in_last  = 1'($urandom_range(1));
         end
         @(negedge clk);
         cyc++;
         if (hold) begin
            check_val("hold_valid", 32'(out_valid), 32'd1);
            check_val("hold_pair", 32'(out_pair), 32'(hp));
            check_val("hold_last", 32'(out_last), 32'(hl));
         end
         if (started && !in_ready) rlow++;
         if (seen_out && !out_valid) gaps++;
         if (out_valid) seen_out = 1;
         if (out_valid && out_ready) begin
            ep = ex_p.pop_front();
            el = ex_l.pop_front();
            check_val("pair", 32'(out_pair), 32'(ep));
            check_val("last", 32'(out_last), 32'(el));
         end
         if (in_valid && in_ready) begin
            ti++;
            started = 1;
         end
         hold = out_valid && !out_ready;
         hp   = out_pair;
         hl   = out_last;
      end
      check_val("timeout_pairs_left", 32'(ex_p.size()), 32'd0);
      check_val("inputs_consumed", 32'(ti), 32'(tx_b.size()));
      tx_b.delete(); tx_l.delete(); ex_p.delete(); ex_l.delete();
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check_val("idle_busy", 32'(busy), 32'd0);
      check_val("idle_in_ready", 32'(in_ready), 32'd1);
   endtask

   initial begin
      int         rl;
      int         gp;
      logic [255:0] v;
      rst_n = 1'b0; in_bit = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
      #1;
      check_val("rst_out_valid", 32'(out_valid), 32'd0);
      check_val("rst_busy", 32'(busy), 32'd0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check_val("rel_in_ready", 32'(in_ready), 32'd1);
      check_val("rel_out_pair", 32'(out_pair), 32'd0);
      check_val("rel_out_last", 32'(out_last), 32'd0);

      // Abort mid-tail with a pending, stalled pair.
      @(posedge clk);
      #1 in_valid = 1'b1; in_bit = 1'b1; in_last = 1'b1; out_ready = 1'b0;
      @(posedge clk);
      #1 in_valid = 1'b0; in_last = 1'b0;
      @(posedge clk);
      #1;
      check_val("mid_busy", 32'(busy), 32'd1);
      check_val("mid_in_ready", 32'(in_ready), 32'd0);
      rst_n = 1'b0;
      #1;
      check_val("abort_out_valid", 32'(out_valid), 32'd0);
      check_val("abort_busy", 32'(busy), 32'd0);
      check_val("abort_out_last", 32'(out_last), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check_val("abort_in_ready", 32'(in_ready), 32'd1);

      // Impulse frame; also confirms sr was cleared by the abort.
      v = '0; v[0] = 1'b1;
      add_frame(1, v);
      run(100, 100, rl, gp);
      check_val("impulse_ready_low", 32'(rl), 32'd6);
      check_val("impulse_gaps", 32'(gp), 32'd0);

      v = '0;
      add_frame(8, v);
      run(100, 100, rl, gp);
      check_val("zeros_ready_low", 32'(rl), 32'd6);
      check_val("zeros_gaps", 32'(gp), 32'd0);

      v = '0; v[0] = 1'b1; v[2] = 1'b1;
      add_frame(3, v);
      v = '0; v[0] = 1'b1;
      add_frame(1, v);
      run(100, 100, rl, gp);
      check_val("b2b_ready_low", 32'(rl), 32'd12);
      check_val("b2b_gaps", 32'(gp), 32'd0);

      v = '0; v[0] = 1'b1; v[2] = 1'b1;
      add_frame(3, v);
      v = '0; v[0] = 1'b1;
      add_frame(1, v);
      run(50, 100, rl, gp);

      for (int f = 0; f < 24; f++) begin
         for (int k = 0; k < 8; k++) v[32*k +: 32] = $urandom;
         add_frame(int'($urandom_range(1, 200)), v);
      end
      run(60, 70, rl, gp);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
